prime_pair_fetch: RTL and testbench

Reader-side consumer of the prime-candidate FIFO. On request it pops two tested primes, rejects a duplicate second value, orders the pair so that p > q, and presents (p, q) to key generation over a valid/ack handshake. It sits between the primality-tester output FIFO and the modulus/CRT key-generation datapath.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/prime_pair_fetch_if.sv | 34 +++
 rtl/prime_pair_fetch.sv | 146 ++++++++++++++
 tb/tb_prime_pair_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA key-generation types: prime word width and the pair-fetch FSM states.
package rsa_pkg;

    localparam int PRIME_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_P,
        ST_CAP_P,
        ST_RD_Q,
        ST_CAP_Q,
        ST_HOLD
    } fetch_state_e;

endpackage

// File: rtl/prime_pair_fetch_if.sv
// Bundle between the pair fetcher, the prime-candidate FIFO read port and key generation.
interface prime_pair_fetch_if #(
    parameter int WIDTH = rsa_pkg::PRIME_WIDTH
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read;
    logic [WIDTH-1:0] p_out;
    logic [WIDTH-1:0] q_out;
    logic             pair_valid;
    logic             pair_ack;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read,
        output p_out,
        output q_out,
        output pair_valid,
        input  pair_ack
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read,
        input  p_out,
        input  q_out,
        input  pair_valid,
        output pair_ack
    );

endinterface

// File: rtl/prime_pair_fetch.sv
// Pops two distinct primes from the tester FIFO and presents them ordered p > q.
//
// state    | meaning
// IDLE     | waiting for start
// RD_P     | pop request for the first prime
// CAP_P    | first prime arrives on fifo_data, latch into p register
// RD_Q     | pop request for the second prime
// CAP_Q    | second prime arrives; discard duplicates or order the pair
// HOLD     | pair presented, waiting for pair_ack
module prime_pair_fetch
    import rsa_pkg::*;
#(
    parameter int WIDTH     = PRIME_WIDTH,
    parameter int TIMEOUT   = 1023,
    parameter int MAX_RETRY = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    starve,
    output logic                    dup_error,
    prime_pair_fetch_if.master      bus
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] p_reg_q, p_reg_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             pair_valid_q, pair_valid_d;
    logic             busy_q, busy_d;
    logic             starve_q, starve_d;
    logic             dup_error_q, dup_error_d;
    logic             fifo_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            p_reg_q      <= '0;
            p_out_q      <= '0;
            q_out_q      <= '0;
            stall_q      <= '0;
            retry_q      <= '0;
            pair_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            starve_q     <= 1'b0;
            dup_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_reg_q      <= p_reg_d;
            p_out_q      <= p_out_d;
            q_out_q      <= q_out_d;
            stall_q      <= stall_d;
            retry_q      <= retry_d;
            pair_valid_q <= pair_valid_d;
            busy_q       <= busy_d;
            starve_q     <= starve_d;
            dup_error_q  <= dup_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        p_reg_d     = p_reg_q;
        p_out_d     = p_out_q;
        q_out_d     = q_out_q;
        stall_d     = stall_q;
        retry_d     = retry_q;
        starve_d    = starve_q;
        dup_error_d = dup_error_q;
        fifo_read   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    starve_d    = 1'b0;
                    dup_error_d = 1'b0;
                    retry_d     = '0;
                    stall_d     = '0;
                    state_d     = ST_RD_P;
                end
            end
            ST_RD_P, ST_RD_Q: begin
                fifo_read = !bus.fifo_empty;
                if (!bus.fifo_empty) begin
                    stall_d = '0;
                    state_d = (state_q == ST_RD_P) ? ST_CAP_P : ST_CAP_Q;
                end else begin
                    // Keep waiting after starve; key generation decides whether to give up.
                    if (stall_q != STALL_MAX) begin
                        stall_d = stall_q + SW'(1);
                    end
                    if (stall_d == STALL_MAX) begin
                        starve_d = 1'b1;
                    end
                end
            end
            ST_CAP_P: begin
                p_reg_d = bus.fifo_data;
                state_d = ST_RD_Q;
            end
            ST_CAP_Q: begin
                if (bus.fifo_data == p_reg_q) begin
                    retry_d = retry_q + RW'(1);
                    if (retry_d > RETRY_MAX) begin
                        dup_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_RD_Q;
                    end
                end else begin
                    p_out_d = (bus.fifo_data > p_reg_q) ? bus.fifo_data : p_reg_q;
                    q_out_d = (bus.fifo_data > p_reg_q) ? p_reg_q : bus.fifo_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.pair_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pair_valid_d = (state_d == ST_HOLD);
        busy_d       = (state_d != ST_IDLE);
    end

    assign bus.fifo_read  = fifo_read;
    assign bus.p_out      = p_out_q;
    assign bus.q_out      = q_out_q;
    assign bus.pair_valid = pair_valid_q;
    assign busy           = busy_q;
    assign starve         = starve_q;
    assign dup_error      = dup_error_q;

endmodule

// File: tb/tb_prime_pair_fetch.sv
// Randomized and directed bench for prime_pair_fetch against a sequence-level pair model.
module tb_prime_pair_fetch;

    localparam int WIDTH     = 32;
    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, starve, dup_error;

    prime_pair_fetch_if #(.WIDTH(WIDTH)) bus();

    prime_pair_fetch #(
        .WIDTH    (WIDTH),
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .starve   (starve),
        .dup_error(dup_error),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pop_cnt = 0;
    logic [WIDTH-1:0] fifo_q[$];

    logic             exp_err;
    logic [WIDTH-1:0] exp_p, exp_q;
    int               exp_pops, exp_lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        fifo_q.push_back(v);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock of the FIFO model: a pop accepted at the edge shows up on fifo_data just after it.
    task automatic step();
        logic rd;
        #1;
        rd = bus.fifo_read;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            bus.fifo_data = fifo_q.pop_front();
            pop_cnt++;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    // Pair expected from the queued sequence: first word is p, skip repeats of it, next distinct word is q.
    task automatic model();
        int d;
        logic [WIDTH-1:0] first;
        first = fifo_q[0];
        d = 0;
        while ((1 + d) < fifo_q.size() && fifo_q[1 + d] == first && d <= MAX_RETRY) d++;
        exp_err = (d > MAX_RETRY);
        if (exp_err) begin
            exp_pops = MAX_RETRY + 2;
            exp_p = '0;
            exp_q = '0;
            exp_lat = 0;
        end else begin
            exp_p = (fifo_q[1 + d] > first) ? fifo_q[1 + d] : first;
            exp_q = (fifo_q[1 + d] > first) ? first : fifo_q[1 + d];
            exp_pops = 2 + d;
            exp_lat = 5 + 2 * d;
        end
    endtask

    task automatic run_pair();
        int lat, pops0, hold_n;
        model();
        pops0 = pop_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        chk("start_clears_dup", dup_error, 0);
        chk("start_clears_starve", starve, 0);
        chk("busy_after_start", busy, 1);
        while (!bus.pair_valid && busy && lat < 60) begin
            start = 1'($urandom_range(0, 1));
            bus.pair_ack = ($urandom_range(0, 2) == 0);
            step();
            lat++;
        end
        start = 1'b0;
        bus.pair_ack = 1'b0;
        if (exp_err) begin
            chk("dup_no_pair", bus.pair_valid, 0);
            chk("dup_error_set", dup_error, 1);
            chk("dup_idle", busy, 0);
            chk("dup_pops", pop_cnt - pops0, exp_pops);
        end else begin
            chk("pair_valid", bus.pair_valid, 1);
            chk("pair_latency", lat, exp_lat);
            chk("p_out", bus.p_out, exp_p);
            chk("q_out", bus.q_out, exp_q);
            chk("pair_pops", pop_cnt - pops0, exp_pops);
            hold_n = $urandom_range(0, 3);
            repeat (hold_n) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("hold_valid", bus.pair_valid, 1);
                chk("hold_p", bus.p_out, exp_p);
                chk("hold_q", bus.q_out, exp_q);
            end
            bus.pair_ack = 1'b1;
            step();
            bus.pair_ack = 1'b0;
            chk("ack_valid_low", bus.pair_valid, 0);
            chk("ack_busy_low", busy, 0);
        end
    endtask

    initial begin
        int n, pops0, d;
        logic [WIDTH-1:0] pv, qv;

        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.pair_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_out", bus.p_out, 0);
        chk("rst_q_out", bus.q_out, 0);
        chk("rst_valid", bus.pair_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {starve, dup_error, bus.fifo_read}, 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        push(32'h0000_0035); push(32'h0000_0061); run_pair();
        push(32'hFFFF_FFFB); push(32'h0000_0007); run_pair();
        push(32'h17); push(32'h17); push(32'h17); push(32'h1D); run_pair();

        // Empty FIFO: starve after TIMEOUT stall cycles, then late data still completes the pair.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            chk("starve_no_read", bus.fifo_read, 0);
            step();
            if (i == TIMEOUT - 1) chk("starve_early", starve, 0);
        end
        chk("starve_set", starve, 1);
        repeat (3) step();
        chk("starve_waits", busy, 1);
        push(32'h05); push(32'h03);
        n = 0;
        while (!bus.pair_valid && n < 20) begin
            step();
            n++;
        end
        chk("starve_pair_valid", bus.pair_valid, 1);
        chk("starve_p", bus.p_out, 32'h05);
        chk("starve_q", bus.q_out, 32'h03);
        bus.pair_ack = 1'b1;
        step();
        bus.pair_ack = 1'b0;
        chk("starve_sticky", starve, 1);
        chk("starve_idle", busy, 0);

        push(32'h0B); push(32'h0B); push(32'h0B); push(32'h0B); run_pair();
        push(32'h2F); push(32'h25); run_pair();

        // Reset while the second prime is being captured.
        push(32'h11); push(32'h13);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        push(32'h29); push(32'h2B);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_read", bus.fifo_read, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_p", bus.p_out, 0);
        chk("mid_rst_q", bus.q_out, 0);
        chk("mid_rst_valid", bus.pair_valid, 0);
        #2 reset_n = 1'b1;
        pops0 = pop_cnt;
        repeat (4) begin
            chk("post_rst_no_read", bus.fifo_read, 0);
            step();
        end
        chk("post_rst_pops", pop_cnt - pops0, 0);
        chk("post_rst_idle", busy, 0);
        run_pair();

        for (int k = 0; k < 24; k++) begin
            pv = $urandom;
            if ($urandom_range(0, 1) == 1) pv[WIDTH-1] = 1'b1;
            qv = $urandom;
            if ($urandom_range(0, 3) == 0) qv[WIDTH-1] = ~pv[WIDTH-1];
            if (qv == pv) qv = ~pv;
            d = $urandom_range(0, MAX_RETRY + 1);
            push(pv);
            repeat (d) push(pv);
            if (d <= MAX_RETRY) push(qv);
            run_pair();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
